tdc_avg_readout: RTL
====================

// Module: tdc_avg_readout
// PURPOSE
//  Synchronous back-end for the delay-line TDC. Registers the raw N_DELAY-bit
//  thermometer word and converts it to a binary code by popcount, which tolerates bubbles.
//  On request it averages 2^AVG_LOG2 consecutive samples and returns sum/mean under a
//  valid/ready handshake, replacing single-shot raw-word readout in the TT wrapper.
// PARAMETERS
//  N_DELAY   128  delay-line taps = thermometer width (>=8)
//  AVG_LOG2  3    log2 of samples per measurement (0..8); N_AVG = 2^AVG_LOG2
//  CODE_W    $clog2(N_DELAY+1)  code width (derived localparam, 8 for defaults)
// PORTS
//  clk         in   1                 clock; same net as the TDC stop edge
//  rst         in   1                 reset, synchronous, active-high
//  i_therm     in   N_DELAY           raw thermometer word from the tdc delay line
//  i_arm       in   1                 start a measurement (level sampled at clk edge)
//  i_ready     in   1                 consumer accepts result
//  o_busy      out  1                 high in ACQ
//  o_valid     out  1                 result available (DONE state)
//  o_sum       out  CODE_W+AVG_LOG2   sum of N_AVG codes
//  o_mean      out  CODE_W            o_sum >> AVG_LOG2 (truncating)
//  o_code      out  CODE_W            live stage-2 code, updates every cycle
//  o_ovf       out  1                 some sample in this measurement had code==N_DELAY
//  o_min       out  CODE_W            minimum code (MINMAX_EN), else 0
//  o_max       out  CODE_W            maximum code (MINMAX_EN), else 0
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state IDLE; all outputs 0; pipeline, counters and accumulators cleared.
//  - Pipeline: S1 registers i_therm every cycle; S2 registers popcount(S1) -> o_code.
//    Tag bit travels with S1/S2: set when S1 captured while ACQ and sample cnt < N_AVG.
//  - FSM IDLE -> ACQ on i_arm; ACQ -> DONE after N_AVG tagged S2 codes accumulated;
//    DONE -> IDLE on i_ready; DONE with i_ready&i_arm -> ACQ (back-to-back).
//  - i_arm in ACQ, or in DONE without i_ready: ignored.
//  - Entry to ACQ clears sum, ovf, cnt; min := all-ones, max := 0.
//  - Capture: edges 1..N_AVG after the arm edge load tagged samples into S1.
//    Accumulate happens at edges 3..N_AVG+2; o_valid rises at edge N_AVG+2.
//  - Sum width CODE_W+AVG_LOG2 never overflows (N_AVG*N_DELAY fits); no saturation.
//  - o_ovf: sticky per measurement, set if any tagged code == N_DELAY (start too early).
//    A code of 0 (stop before start) is legal and not flagged.
//  - o_sum/o_mean/o_ovf/o_min/o_max: stable while o_valid=1; updated only during ACQ.
//    They keep the last result in IDLE.
//  - o_valid deasserts the cycle after the edge where i_ready=1 was sampled.
//  - rst mid-ACQ or mid-DONE: abort, back to IDLE, partial results discarded (all 0).
//  - AVG_LOG2=0: single-sample mode, o_mean == o_sum.
// CONFIGURATION
//  TDC_MINMAX_EN defined: per-measurement min/max of tagged codes on o_min/o_max.
//    Comparators run in the accumulate stage; the capture-to-valid latency is unchanged.
//  Not defined: no comparators or registers built; o_min=o_max=0 constant; ports stay.
// TESTING
//  1 rst=1 two cycles, i_arm=1 -> all outputs 0, o_busy stays 0 while rst held.
//  2 N_AVG=8, i_therm=2^37-1 const, pulse i_arm -> o_valid at edge 10, o_sum=296, o_mean=37.
//  3 samples 10,11,...,17 (popcount), bubbles inserted -> o_sum=108, o_mean=13,
//    with MINMAX o_min=10, o_max=17.
//  4 one sample all-ones (128) among 7x code 5 -> o_ovf=1, o_sum=163; next measurement clears o_ovf.
//  5 hold i_ready=0 for 20 cycles in DONE with i_arm pulses -> outputs stable, no restart;
//    then i_ready=1 & i_arm=1 -> straight to ACQ, o_valid low next cycle.
//  6 rst at 3rd ACQ cycle -> IDLE, o_sum=0, o_valid=0; fresh arm yields a correct full result.

Source files
------------

// File: rtl/tdc_avg_readout_if.sv
// Handshake/data bundle between the TDC averaging readout and its consumer.
// The slave modport is the readout's view; master is the wrapper/consumer side.
interface tdc_avg_readout_if #(
  parameter int N_DELAY  = 128,
  parameter int AVG_LOG2 = 3,
  parameter int CODE_W   = $clog2(N_DELAY + 1)
);
  logic [N_DELAY-1:0]         i_therm;
  logic                       i_arm;
  logic                       i_ready;
  logic                       o_busy;
  logic                       o_valid;
  logic [CODE_W+AVG_LOG2-1:0] o_sum;
  logic [CODE_W-1:0]          o_mean;
  logic [CODE_W-1:0]          o_code;
  logic                       o_ovf;
  logic [CODE_W-1:0]          o_min;
  logic [CODE_W-1:0]          o_max;

  modport master (
    output i_therm, i_arm, i_ready,
    input  o_busy, o_valid, o_sum, o_mean, o_code, o_ovf, o_min, o_max
  );

  modport slave (
    input  i_therm, i_arm, i_ready,
    output o_busy, o_valid, o_sum, o_mean, o_code, o_ovf, o_min, o_max
  );
endinterface

// File: rtl/tdc_avg_readout.sv
// Delay-line TDC back-end: thermometer register, popcount code, 2^AVG_LOG2-sample averaging.
// Optional feature macro: TDC_MINMAX_EN (per-measurement min/max of the tagged codes).
module tdc_avg_readout #(
  parameter int N_DELAY  = 128,
  parameter int AVG_LOG2 = 3
) (
  input logic               clk,
  input logic               rst,
  tdc_avg_readout_if.slave  bus
);
  localparam int CODE_W = $clog2(N_DELAY + 1);
  localparam int SUM_W  = CODE_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]  N_AVG    = CNT_W'(2 ** AVG_LOG2);
  localparam logic [CNT_W-1:0]  LAST_ACC = N_AVG - 1'b1;
  localparam logic [CODE_W-1:0] FULL_CODE = CODE_W'(N_DELAY);

  typedef enum logic [1:0] {IDLE, ACQ, DONE} state_e;

  state_e             state_q, state_d;
  logic [N_DELAY-1:0] s1Therm_q;
  logic               s1Tag_q;
  logic [CODE_W-1:0]  s2Code_q;
  logic               s2Tag_q;
  logic [CODE_W-1:0]  popCnt;
  logic [CNT_W-1:0]   capCnt_q;
  logic [CNT_W-1:0]   accCnt_q;
  logic [SUM_W-1:0]   sum_q;
  logic               ovf_q;
  logic               startAcq;
  logic               capTag;
  logic               accEn;
  logic               lastAcc;

  // Popcount rather than edge search so bubbles in the thermometer cost no accuracy.
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      popCnt = popCnt + CODE_W'(s1Therm_q[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    startAcq = 1'b0;
    capTag   = (state_q == ACQ) && (capCnt_q < N_AVG);
    accEn    = (state_q == ACQ) && s2Tag_q;
    lastAcc  = accEn && (accCnt_q == LAST_ACC);
    case (state_q)
      IDLE: begin
        if (bus.i_arm) begin
          state_d  = ACQ;
          startAcq = 1'b1;
        end
      end
      ACQ: begin
        if (lastAcc) state_d = DONE;
      end
      DONE: begin
        if (bus.i_ready) begin
          if (bus.i_arm) begin
            state_d  = ACQ;
            startAcq = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The tag rides alongside the sample so only in-window captures are accumulated.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Therm_q <= '0;
      s1Tag_q   <= 1'b0;
      s2Code_q  <= '0;
      s2Tag_q   <= 1'b0;
    end else begin
      s1Therm_q <= bus.i_therm;
      s1Tag_q   <= capTag;
      s2Code_q  <= popCnt;
      s2Tag_q   <= s1Tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      capCnt_q <= '0;
      accCnt_q <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (startAcq) begin
      capCnt_q <= '0;
      accCnt_q <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (capTag) capCnt_q <= capCnt_q + 1'b1;
      if (accEn) begin
        accCnt_q <= accCnt_q + 1'b1;
        sum_q    <= sum_q + SUM_W'(s2Code_q);
        ovf_q    <= ovf_q | (s2Code_q == FULL_CODE);
      end
    end
  end

`ifdef TDC_MINMAX_EN
  logic [CODE_W-1:0] min_q;
  logic [CODE_W-1:0] max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (startAcq) begin
      min_q <= '1;
      max_q <= '0;
    end else if (accEn) begin
      if (s2Code_q < min_q) min_q <= s2Code_q;
      if (s2Code_q > max_q) max_q <= s2Code_q;
    end
  end

  assign bus.o_min = min_q;
  assign bus.o_max = max_q;
`else
  assign bus.o_min = '0;
  assign bus.o_max = '0;
`endif

  assign bus.o_busy  = (state_q == ACQ);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_sum   = sum_q;
  assign bus.o_mean  = sum_q[AVG_LOG2 +: CODE_W];
  assign bus.o_code  = s2Code_q;
  assign bus.o_ovf   = ovf_q;
endmodule
